fp_cond_reduce: RTL and testbench

- Downstream stage of the L3-to-unsigned conversion.
- Takes the converted non-negative integer, which is bounded by 2^Q_BITS·p, and returns its canonical residue in [0, p).
- Uses restoring reduction: one trial subtraction of p·2^k per quotient bit, on a pipelined limb subtractor.
- Sits between the polynomial-arithmetic datapath and the Fp consumers, with a valid/ready handshake on both sides.

---
 rtl/fp_cond_reduce_pkg.sv | 22 ++
 rtl/fp_wide_sub_pipe.sv | 79 +++++++
 rtl/fp_cond_reduce.sv | 128 ++++++++++++
 tb/tb_fp_cond_reduce.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fp_cond_reduce_pkg.sv
// Shared BN254 field types and constants for the Fp conditional-reduce stage.
package fp_cond_reduce_pkg;

  localparam int BN254_FP_W = 272;

  typedef logic [BN254_FP_W-1:0] uint_fp_t;

  localparam uint_fp_t BN254_P =
    272'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  // Quotient bits left over by the L3-to-unsigned converter (input < 2^4 * p).
  localparam int REDUCE_Q_BITS = 4;

  // Reduction FSM states, named for waveform readability.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } red_state_e;

endpackage

// File: rtl/fp_wide_sub_pipe.sv
// Three-cycle, four-limb carry-select subtractor: diff = x - y, borrow = ~carry-out.
// Stage 1 forms limb sums for both carry-ins, stage 2 merges limb pairs,
// stage 3 merges the two halves. The top limb absorbs any width remainder.
module fp_wide_sub_pipe #(
  parameter int W      = 276,
  parameter int LIMB_W = W / 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int L = LIMB_W;
  localparam int T = W - 3 * L;  // top limb width
  localparam int H = W - 2 * L;  // upper half width

  logic [W-1:0] yn;
  assign yn = ~y;

  // Limb sums: limb 0 sees the +1 of two's complement, limbs 1..3 are
  // precomputed for carry-in 0 (a) and carry-in 1 (b).
  logic [L:0] l0, l1a, l1b, l2a, l2b;
  logic [T:0] l3a, l3b;
  assign l0  = {1'b0, x[L-1:0]} + {1'b0, yn[L-1:0]} + (L+1)'(1);
  assign l1a = {1'b0, x[2*L-1:L]} + {1'b0, yn[2*L-1:L]};
  assign l1b = l1a + (L+1)'(1);
  assign l2a = {1'b0, x[3*L-1:2*L]} + {1'b0, yn[3*L-1:2*L]};
  assign l2b = l2a + (L+1)'(1);
  assign l3a = {1'b0, x[W-1:3*L]} + {1'b0, yn[W-1:3*L]};
  assign l3b = l3a + (T+1)'(1);

  logic [L:0] s1_l0, s1_l1a, s1_l1b, s1_l2a, s1_l2b;
  logic [T:0] s1_l3a, s1_l3b;

  logic [2*L-1:0] s2_lo;
  logic           s2_lo_c;
  logic [H-1:0]   s2_hi0, s2_hi1;
  logic           s2_hi0_c, s2_hi1_c;

  logic           s3_c;
  logic [2:0]     vld;

  // Valid shift register: the only pipeline state that must come up cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else        vld <= {vld[1:0], in_valid};
  end

  // Datapath stages, qualified by vld.
  // NOTE: data registers carry no reset; vld alone says whether they hold anything meaningful.
  always_ff @(posedge clk) begin
    s1_l0  <= l0;
    s1_l1a <= l1a;
    s1_l1b <= l1b;
    s1_l2a <= l2a;
    s1_l2b <= l2b;
    s1_l3a <= l3a;
    s1_l3b <= l3b;

    s2_lo    <= {s1_l0[L] ? s1_l1b[L-1:0] : s1_l1a[L-1:0], s1_l0[L-1:0]};
    s2_lo_c  <= s1_l0[L] ? s1_l1b[L] : s1_l1a[L];
    s2_hi0   <= {s1_l2a[L] ? s1_l3b[T-1:0] : s1_l3a[T-1:0], s1_l2a[L-1:0]};
    s2_hi0_c <= s1_l2a[L] ? s1_l3b[T] : s1_l3a[T];
    s2_hi1   <= {s1_l2b[L] ? s1_l3b[T-1:0] : s1_l3a[T-1:0], s1_l2b[L-1:0]};
    s2_hi1_c <= s1_l2b[L] ? s1_l3b[T] : s1_l3a[T];

    diff <= {s2_lo_c ? s2_hi1 : s2_hi0, s2_lo};
    s3_c <= s2_lo_c ? s2_hi1_c : s2_hi0_c;
  end

  assign out_valid = vld[2];
  assign borrow    = ~s3_c;

endmodule

// File: rtl/fp_cond_reduce.sv
// Restoring reduction of a value < 2^Q_BITS * p to its canonical residue in [0, p).
// One trial subtraction of p << k per quotient bit, k = Q_BITS-1 down to 0.
module fp_cond_reduce
  import fp_cond_reduce_pkg::*;
#(
  parameter int               FP_W    = BN254_FP_W,
  parameter int               Q_BITS  = REDUCE_Q_BITS,
  parameter int               SUB_LAT = 3,
  parameter logic [FP_W-1:0]  P_MOD   = BN254_P
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FP_W+Q_BITS-1:0] din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FP_W-1:0]        dout,
  output logic                   err
);

  localparam int W     = FP_W + Q_BITS;
  localparam int K_W   = (Q_BITS > 1) ? $clog2(Q_BITS) : 1;
  localparam int CNT_W = (SUB_LAT > 1) ? $clog2(SUB_LAT) : 1;

  red_state_e       state_q, state_d;
  logic [W-1:0]     r_q, r_d, r_upd;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ov_d, err_d;
  logic [FP_W-1:0]  dout_d;

  logic             sub_go, sub_valid, sub_borrow;
  logic [W-1:0]     sub_y, sub_diff;

  assign sub_y    = {{Q_BITS{1'b0}}, P_MOD} << k_q;
  assign in_ready = (state_q == IDLE);

  fp_wide_sub_pipe #(
    .W      (W),
    .LIMB_W (FP_W / 4)
  ) u_sub (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (sub_go),
    .x         (r_q),
    .y         (sub_y),
    .out_valid (sub_valid),
    .diff      (sub_diff),
    .borrow    (sub_borrow)
  );

  // Next-state and datapath control; every target defaults to hold.
  always_comb begin
    // NOTE: each signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    ov_d    = out_valid;
    dout_d  = dout;
    err_d   = err;
    sub_go  = 1'b0;
    // Restoring step: keep the difference only when the trial did not borrow.
    r_upd   = sub_borrow ? r_q : sub_diff;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = din;
          k_d     = K_W'(Q_BITS - 1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sub_go  = 1'b1;
        cnt_d   = CNT_W'(SUB_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (sub_valid) begin
          r_d = r_upd;
          if (k_q == '0) begin
            state_d = DONE;
            ov_d    = 1'b1;
            dout_d  = r_upd[FP_W-1:0];
            err_d   = (r_upd[W-1:FP_W] != '0) || (r_upd[FP_W-1:0] >= P_MOD);
          end else begin
            k_d     = k_q - K_W'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and working registers; outputs are registered and held through DONE.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      out_valid <= ov_d;
      dout      <= dout_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_fp_cond_reduce.sv
// Directed and scoreboarded checks of fp_cond_reduce with the BN254 modulus.
module tb_fp_cond_reduce;
  import fp_cond_reduce_pkg::*;

  localparam int FP_W = BN254_FP_W;
  localparam int W    = FP_W + REDUCE_Q_BITS;
  localparam int NRND = 200;

  logic            clk, rst_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0]    din;
  logic [FP_W-1:0] dout;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] p_w, mask253;
  logic [W-1:0] vals[NRND];
  logic [W-1:0] exps[NRND];

  fp_cond_reduce dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One transaction with out_ready high. Latency is counted in cycles with the
  // accept cycle as cycle 1, so out_valid shows in cycle 17 (16 edges after accept).
  task automatic run_one(input string tag, input logic [W-1:0] v, input logic [W-1:0] exp_v,
                         input logic exp_err, input bit chk_dout);
    int cyc;
    @(negedge clk);
    in_valid  = 1'b1;
    din       = v;
    out_ready = 1'b1;
    check({tag, "_in_ready_idle"}, W'(in_ready), W'(1));
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, W'(in_ready), W'(0));
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check({tag, "_latency"}, W'(cyc), W'(17));
    check({tag, "_out_valid"}, W'(out_valid), W'(1));
    check({tag, "_err"}, W'(err), W'(exp_err));
    if (chk_dout) check({tag, "_dout"}, W'(dout), exp_v);
    @(negedge clk);
    check({tag, "_out_valid_drop"}, W'(out_valid), W'(0));
    check({tag, "_in_ready_back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int cyc, sent, got, guard, ov_seen;
    p_w      = W'(BN254_P);
    mask253  = (W'(1) << 253) - W'(1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    din      = '0;

    // Reset values while held in reset.
    #12;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_dout", W'(dout), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Main function and exact boundaries.
    run_one("p15_plus5", p_w * 15 + W'(5), W'(5), 1'b0, 1'b1);
    run_one("eq_p", p_w, W'(0), 1'b0, 1'b1);
    run_one("p_minus1", p_w - W'(1), p_w - W'(1), 1'b0, 1'b1);
    run_one("zero", W'(0), W'(0), 1'b0, 1'b1);
    run_one("16p_minus1", (p_w << 4) - W'(1), p_w - W'(1), 1'b0, 1'b1);

    // Stall: result held while out_ready is low.
    @(negedge clk);
    in_valid  = 1'b1;
    din       = (p_w << 1) + W'(7);
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_dout", W'(dout), W'(7));
      check("stall_out_valid", W'(out_valid), W'(1));
      check("stall_in_ready", W'(in_ready), W'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_out_valid", W'(out_valid), W'(0));
    check("stall_release_in_ready", W'(in_ready), W'(1));

    // Range violation.
    run_one("over_range", (p_w << 4) + W'(3), W'(0), 1'b1, 1'b0);

    // Back-to-back stream: din = q*p + rem with rem < 2^253 < p, so din mod p = rem.
    for (int i = 0; i < NRND; i++) begin
      logic [W-1:0] rem;
      rem     = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
      rem     = rem & mask253;
      vals[i] = W'($urandom_range(0, 15)) * p_w + rem;
      exps[i] = rem;
    end
    sent = 0;
    got = 0;
    guard = 0;
    while (got < NRND && guard < 20000) begin
      @(negedge clk);
      guard++;
      in_valid  = (sent < NRND);
      din       = vals[(sent < NRND) ? sent : NRND - 1];
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        check("stream_dout", W'(dout), exps[got]);
        check("stream_err", W'(err), W'(0));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    check("stream_received", W'(got), W'(NRND));
    check("stream_sent", W'(sent), W'(NRND));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stream_no_extra", W'(out_valid), W'(0));

    // Reset mid-operation.
    @(negedge clk);
    in_valid = 1'b1;
    din      = p_w * 9 + W'(11);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("midrst_busy", W'(in_ready), W'(0));
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("midrst_no_stale", W'(ov_seen), W'(0));
    run_one("after_rst", p_w + W'(1), W'(1), 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
